// File: rtl/rem_unit.sv
// rtl/rem_unit.sv - sequential sign-magnitude remainder unit (restoring shift-subtract)
// Optional quotient output enabled by defining REM_QUOTIENT_EN.
module rem_unit #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] numerator,
   input  logic [W-1:0] denominator,
   output logic [W-1:0] remainder,
   output logic         divbyzero,
   output logic         busy,
   output logic         done
`ifdef REM_QUOTIENT_EN
   ,
   output logic [W-1:0] quotient
`endif
);

   localparam int M  = W - 1;
   localparam int CW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t         state_q, state_d;
   logic           sign_q;
   logic [M-1:0]   num_q, den_q, prem_q;
   logic [CW-1:0]  cnt_q;

   logic           den_zero, last, fits;
   logic [M:0]     shifted;
   logic [M-1:0]   diff, prem_n;
   logic           den_sign_unused;

   assign den_sign_unused = denominator[W-1];
   assign den_zero = ~|denominator[M-1:0];
   assign last     = (cnt_q == CW'(M - 1));

   // Partial remainder stays below the divisor, so only the shifted value needs the extra bit.
   assign shifted = {prem_q, num_q[M-1]};
   assign fits    = (shifted >= {1'b0, den_q});
   assign diff    = shifted[M-1:0] - den_q;
   assign prem_n  = fits ? diff : shifted[M-1:0];

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_FIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = den_zero ? S_FIN : S_CALC;
         S_CALC:  if (last) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

`ifdef REM_QUOTIENT_EN
   logic [M-1:0] quo_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_q    <= 1'b0;
         num_q     <= '0;
         den_q     <= '0;
         prem_q    <= '0;
         cnt_q     <= '0;
         remainder <= '0;
         divbyzero <= 1'b0;
`ifdef REM_QUOTIENT_EN
         quo_q     <= '0;
         quotient  <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sign_q <= numerator[W-1];
                  num_q  <= numerator[M-1:0];
                  den_q  <= denominator[M-1:0];
                  prem_q <= '0;
                  cnt_q  <= '0;
`ifdef REM_QUOTIENT_EN
                  quo_q  <= '0;
`endif
                  // A zero divisor skips the iterations and publishes straight away.
                  if (den_zero) begin
                     remainder <= numerator;
                     divbyzero <= 1'b1;
`ifdef REM_QUOTIENT_EN
                     quotient  <= {numerator[W-1], {M{1'b1}}};
`endif
                  end
               end
            end
            S_CALC: begin
               prem_q <= prem_n;
               num_q  <= num_q << 1;
               cnt_q  <= cnt_q + CW'(1);
`ifdef REM_QUOTIENT_EN
               quo_q  <= (quo_q << 1) | M'(fits);
`endif
               if (last) begin
                  remainder <= {sign_q, prem_n};
                  divbyzero <= 1'b0;
`ifdef REM_QUOTIENT_EN
                  quotient  <= {sign_q, (quo_q << 1) | M'(fits)};
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rem_unit.sv
// tb/tb_rem_unit.sv - self-checking bench for rem_unit against an arithmetic reference model
module tb_rem_unit;

   localparam int W = 3;
   localparam int M = W - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] numerator = '0;
   logic [W-1:0] denominator = '0;
   logic [W-1:0] remainder;
   logic         divbyzero;
   logic         busy;
   logic         done;
`ifdef REM_QUOTIENT_EN
   logic [W-1:0] quotient;
`endif

   int checks = 0;
   int errors = 0;

   rem_unit #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .numerator   (numerator),
      .denominator (denominator),
      .remainder   (remainder),
      .divbyzero   (divbyzero),
      .busy        (busy),
      .done        (done)
`ifdef REM_QUOTIENT_EN
      ,
      .quotient    (quotient)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge; leaves the unit idle one cycle after its done pulse.
   task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input bit noise);
      int nm, dm, cyc;
      bit z;
      logic [W-1:0] er;
      nm = int'(n[M-1:0]);
      dm = int'(d[M-1:0]);
      z  = (dm == 0);
      er = z ? n : {n[W-1], M'(nm % dm)};
      numerator   = n;
      denominator = d;
      start       = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check("busy_after_start", 32'(busy), 32'd1);
         if (!done && noise) begin
            numerator   = W'($urandom);
            denominator = W'($urandom);
            start       = 1'($urandom_range(0, 1));
         end else begin
            start = 1'b0;
         end
      end while (!done && cyc < 20);
      start = 1'b0;
      check("latency", 32'(cyc), z ? 32'd1 : 32'(M + 1));
      check("remainder", 32'(remainder), 32'(er));
      check("divbyzero", 32'(divbyzero), 32'(z));
`ifdef REM_QUOTIENT_EN
      check("quotient", 32'(quotient), 32'(z ? {n[W-1], {M{1'b1}}} : {n[W-1], M'(nm / dm)}));
`endif
      @(negedge clk);
      check("done_single", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("remainder_held", 32'(remainder), 32'(er));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] v;
      repeat (2) @(negedge clk);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_divbyzero", 32'(divbyzero), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(3'b011, 3'b010, 1'b0);
      run_op(3'b101, 3'b011, 1'b0);
      run_op(3'b111, 3'b100, 1'b0);

      for (int i = 0; i < 64; i++) begin
         v = 6'(i);
         run_op(v[5:3], v[2:0], 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 40; i++) run_op(W'($urandom), W'($urandom), 1'b1);

      run_op(3'b111, 3'b100, 1'b0);
      numerator   = 3'b011;
      denominator = 3'b001;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_before_abort", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_remainder", 32'(remainder), 32'd0);
      check("abort_divbyzero", 32'(divbyzero), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(3'b011, 3'b010, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
